// File: rtl/lcd_controller.sv
// lcd_controller: HD44780 4-bit power-on init sequencer and byte-write front end for lcd_transfer.
// Every byte goes out as two nibble transfers; completion comes back from lcd_transfer as commandDone.
module lcd_controller #(
    parameter int unsigned FREQ     = 50000000,
    parameter int unsigned PWRUP_US = 15000,
    parameter int unsigned WAIT0_US = 4100,
    parameter int unsigned WAIT_US  = 100
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        wr_req,
    input  logic [7:0]  wr_data,
    input  logic        wr_rs,
    output logic        wr_ack,
    output logic        ready,
    output logic        init_done,
    output logic        sendCommand,
    output logic [3:0]  command,
    output logic        command_rs,
    output logic [20:0] commandDelay,
    output logic        read_busy,
    output logic        mode4bit,
    input  logic        commandDone
);
    localparam int unsigned CYC_PER_US = FREQ / 1000000;
    localparam logic [20:0] PWRUP_LAST = 21'(PWRUP_US * CYC_PER_US - 1);
    localparam logic [20:0] WAIT0_LAST = 21'(WAIT0_US * CYC_PER_US - 1);
    localparam logic [20:0] WAIT_LAST  = 21'(WAIT_US * CYC_PER_US - 1);

    typedef enum logic [2:0] {
        PWR_WAIT, INIT_NIB, INIT_WAIT, INIT_HI, INIT_LO, IDLE, WR_HI, WR_LO
    } state_t;

    state_t      state, state_n;
    logic [20:0] timer, timer_n;
    logic [2:0]  step, step_n;
    logic        gap, gap_n;
    logic [7:0]  wbyte, wbyte_n;
    logic        wrs, wrs_n;
    logic        ack_n, ready_n, done_n, send_n, rs_n, busy_n, m4_n;
    logic [3:0]  cmd_n;
    logic [7:0]  init_cur, init_nxt;
    logic [20:0] wait_last;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h28;
            3'd1:    return 8'h08;
            3'd2:    return 8'h01;
            3'd3:    return 8'h06;
            3'd4:    return 8'h0C;
            default: return 8'h00;
        endcase
    endfunction

    assign commandDelay = '0;
    assign init_cur     = init_byte(step);
    assign init_nxt     = init_byte(step + 3'd1);
    assign wait_last    = (step == 3'd0) ? WAIT0_LAST : WAIT_LAST;

    // Nibbles are issued on the transition into each wait-for-done state, so the
    // registered command fields are already valid in the cycle sendCommand is high.
    // 'gap' holds one extra cycle after commandDone before the next issue.
    always_comb begin
        state_n = state;
        timer_n = '0;
        step_n  = step;
        gap_n   = gap;
        wbyte_n = wbyte;
        wrs_n   = wrs;
        ack_n   = 1'b0;
        done_n  = init_done;
        send_n  = 1'b0;
        cmd_n   = command;
        rs_n    = command_rs;
        busy_n  = read_busy;
        m4_n    = mode4bit;
        case (state)
            PWR_WAIT: begin
                if (timer == PWRUP_LAST) begin
                    state_n = INIT_NIB;
                    send_n  = 1'b1;
                    cmd_n   = 4'h3;
                    rs_n    = 1'b0;
                    busy_n  = 1'b0;
                    m4_n    = 1'b0;
                end else begin
                    timer_n = timer + 21'd1;
                end
            end
            INIT_NIB: begin
                if (commandDone) state_n = INIT_WAIT;
            end
            INIT_WAIT: begin
                if (timer == wait_last) begin
                    send_n = 1'b1;
                    rs_n   = 1'b0;
                    busy_n = 1'b0;
                    if (step == 3'd3) begin
                        state_n = INIT_HI;
                        step_n  = '0;
                        cmd_n   = init_byte(3'd0) >> 4;
                        m4_n    = 1'b1;
                    end else begin
                        state_n = INIT_NIB;
                        step_n  = step + 3'd1;
                        cmd_n   = (step == 3'd2) ? 4'h2 : 4'h3;
                        m4_n    = 1'b0;
                    end
                end else begin
                    timer_n = timer + 21'd1;
                end
            end
            INIT_HI: begin
                if (gap) begin
                    gap_n   = 1'b0;
                    state_n = INIT_LO;
                    send_n  = 1'b1;
                    cmd_n   = init_cur[3:0];
                    busy_n  = 1'b1;
                end else if (commandDone) begin
                    gap_n = 1'b1;
                end
            end
            INIT_LO: begin
                if (gap) begin
                    gap_n = 1'b0;
                    if (step == 3'd4) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = INIT_HI;
                        step_n  = step + 3'd1;
                        send_n  = 1'b1;
                        cmd_n   = init_nxt[7:4];
                        busy_n  = 1'b0;
                    end
                end else if (commandDone) begin
                    gap_n = 1'b1;
                end
            end
            IDLE: begin
                if (wr_req) begin
                    state_n = WR_HI;
                    wbyte_n = wr_data;
                    wrs_n   = wr_rs;
                    ack_n   = 1'b1;
                    send_n  = 1'b1;
                    cmd_n   = wr_data[7:4];
                    rs_n    = wr_rs;
                    busy_n  = 1'b0;
                    m4_n    = 1'b1;
                end
            end
            WR_HI: begin
                if (gap) begin
                    gap_n   = 1'b0;
                    state_n = WR_LO;
                    send_n  = 1'b1;
                    cmd_n   = wbyte[3:0];
                    rs_n    = wrs;
                    busy_n  = 1'b1;
                end else if (commandDone) begin
                    gap_n = 1'b1;
                end
            end
            WR_LO: begin
                if (gap) begin
                    gap_n   = 1'b0;
                    state_n = IDLE;
                end else if (commandDone) begin
                    gap_n = 1'b1;
                end
            end
            default: state_n = PWR_WAIT;
        endcase
        ready_n = (state_n == IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= PWR_WAIT;
            timer       <= '0;
            step        <= '0;
            gap         <= 1'b0;
            wbyte       <= '0;
            wrs         <= 1'b0;
            wr_ack      <= 1'b0;
            ready       <= 1'b0;
            init_done   <= 1'b0;
            sendCommand <= 1'b0;
            command     <= '0;
            command_rs  <= 1'b0;
            read_busy   <= 1'b0;
            mode4bit    <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            step        <= step_n;
            gap         <= gap_n;
            wbyte       <= wbyte_n;
            wrs         <= wrs_n;
            wr_ack      <= ack_n;
            ready       <= ready_n;
            init_done   <= done_n;
            sendCommand <= send_n;
            command     <= cmd_n;
            command_rs  <= rs_n;
            read_busy   <= busy_n;
            mode4bit    <= m4_n;
        end
    end
endmodule
